// File: rtl/frame_ctrl.sv
// Frame sequencer around the classifier core: streams one frame of pixels in, collects detections.
// Pixel path is zero-latency pass-through gated by din_ready; detection input never stalls (overflow drops).
module frame_ctrl #(
    parameter int W_DATA     = 8,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W_DET      = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [W_DATA-1:0] pix_data,
    output logic              din_valid,
    input  logic              din_ready,
    output logic [W_DATA:0]   din_data,
    output logic              core_rst,
    input  logic              det_in_valid,
    output logic              det_in_ready,
    input  logic [W_DET-1:0]  det_in_data,
    output logic              det_valid,
    input  logic              det_ready,
    output logic [W_DET-2:0]  det_data,
    output logic [15:0]       det_count,
    output logic              overflow,
    output logic              busy,
    output logic              irq,
    input  logic              irq_clr
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {FLUSH, IDLE, LOAD, RUN, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       rst_cnt;
    logic                after_frame;
    logic                in_load;
    logic [PW-1:0]       pix_cnt;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         fifo_cnt;
    logic [W_DET-2:0]    mem [FIFO_DEPTH];

    logic last, pix_xfer, start_fire, det_acc, det_marker, fifo_full, pop, push;

    assign last       = (pix_cnt == PW'(NPIX - 1));
    assign pix_xfer   = in_load & pix_valid & din_ready;
    assign start_fire = start_valid & start_ready;
    assign det_acc    = det_in_valid & det_in_ready;
    assign det_marker = det_in_data[W_DET-1];
    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign pop        = det_valid & det_ready;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign push       = det_acc & ~det_marker & (~fifo_full | pop);

    assign pix_ready  = in_load & din_ready;
    assign din_valid  = in_load & pix_valid;
    assign din_data   = {last, pix_data};
    assign det_valid  = (fifo_cnt != '0);
    assign det_data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FLUSH;
            rst_cnt      <= CW'(RST_CYCLES - 1);
            after_frame  <= 1'b0;
            core_rst     <= 1'b1;
            busy         <= 1'b1;
            irq          <= 1'b0;
            start_ready  <= 1'b0;
            det_in_ready <= 1'b0;
            in_load      <= 1'b0;
            pix_cnt      <= '0;
            det_count    <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    if (rst_cnt == '0) begin
                        core_rst    <= 1'b0;
                        busy        <= 1'b0;
                        after_frame <= 1'b0;
                        if (after_frame) begin
                            state <= DONE;
                            irq   <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            start_ready <= 1'b1;
                        end
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (start_valid) begin
                        state       <= LOAD;
                        start_ready <= 1'b0;
                        in_load     <= 1'b1;
                        busy        <= 1'b1;
                        pix_cnt     <= '0;
                        det_count   <= '0;
                        overflow    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (pix_xfer) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (last) begin
                            state        <= RUN;
                            in_load      <= 1'b0;
                            det_in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (det_in_valid) begin
                        if (det_marker) begin
                            state        <= FLUSH;
                            rst_cnt      <= CW'(RST_CYCLES - 1);
                            after_frame  <= 1'b1;
                            core_rst     <= 1'b1;
                            det_in_ready <= 1'b0;
                        end else begin
                            if (det_count != 16'hFFFF)
                                det_count <= det_count + 16'd1;
                            if (fifo_full && !pop)
                                overflow <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (irq_clr) begin
                        state       <= IDLE;
                        irq         <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (start_fire) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= det_in_data[W_DET-2:0];
    end
endmodule
